pla_vector_sweeper: RTL

- Stimulus/response end for the flattened single-output PLA evaluators (x0..xN-1 -> y0).
- Enumerates input vectors, drives them into an evaluator over a valid/ready handshake, and collects the y0 responses in order.
- Checks autosymmetry under a programmable translation alpha, i.e. f(v) == f(v ^ alpha), and accumulates an onset count and a MISR signature.
- Used for on-chip equivalence and regression checking of the optimised netlists.

---
 rtl/pla_vector_sweeper.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/pla_vector_sweeper.sv
// Vector sweeper for single-output PLA evaluators: issues (v, v^alpha) pairs, checks
// autosymmetry, counts onsets and builds a MISR signature. Option: PLA_SWEEP_MISMATCH_STOP_EN.
module pla_vector_sweeper #(
    parameter int N_IN  = 24,
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_IN-1:0]  base,
    input  logic [CNT_W-1:0] sweep_len,
    input  logic [N_IN-1:0]  alpha,
    output logic [N_IN-1:0]  x_out,
    output logic             x_valid,
    input  logic             x_ready,
    input  logic             y_in,
    input  logic             y_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] onset_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [N_IN-1:0]  first_mismatch,
    output logic [31:0]      signature,
    output logic             protocol_err
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT,
        DONE
    } state_t;

    localparam logic [N_IN-1:0]  V_ONE    = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      MISR_TAP = 32'h0040_0007;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  v_q, v_d;
    logic [N_IN-1:0]  alpha_q, alpha_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] pairs_q, pairs_d;
    logic [1:0]       iss_q, iss_d;
    logic [1:0]       rsp_q, rsp_d;
    logic             ya_q, ya_d;
    logic [CNT_W-1:0] onset_q, onset_d;
    logic [CNT_W-1:0] mm_q, mm_d;
    logic [N_IN-1:0]  first_q, first_d;
    logic [31:0]      sig_q, sig_d;
    logic             perr_q, perr_d;

    logic             hs;
    logic [1:0]       iss_eff;
    logic [CNT_W-1:0] pairs_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + C_ONE;
    endfunction

    function automatic logic [31:0] misr_next(input logic [31:0] s, input logic y);
        return ({s[30:0], 1'b0} ^ (s[31] ? MISR_TAP : 32'h0)) ^ {31'b0, y};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            v_q     <= '0;
            alpha_q <= '0;
            len_q   <= '0;
            pairs_q <= '0;
            iss_q   <= '0;
            rsp_q   <= '0;
            ya_q    <= 1'b0;
            onset_q <= '0;
            mm_q    <= '0;
            first_q <= '0;
            sig_q   <= '1;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            alpha_q <= alpha_d;
            len_q   <= len_d;
            pairs_q <= pairs_d;
            iss_q   <= iss_d;
            rsp_q   <= rsp_d;
            ya_q    <= ya_d;
            onset_q <= onset_d;
            mm_q    <= mm_d;
            first_q <= first_d;
            sig_q   <= sig_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        alpha_d    = alpha_q;
        len_d      = len_q;
        pairs_d    = pairs_q;
        iss_d      = iss_q;
        rsp_d      = rsp_q;
        ya_d       = ya_q;
        onset_d    = onset_q;
        mm_d       = mm_q;
        first_d    = first_q;
        sig_d      = sig_q;
        perr_d     = perr_q;
        x_valid    = 1'b0;
        x_out      = '0;
        hs         = 1'b0;
        pairs_next = pairs_q + C_ONE;

        case (state_q)
            IDLE: begin
                if (start) begin
                    v_d     = base;
                    alpha_d = alpha;
                    len_d   = sweep_len;
                    pairs_d = '0;
                    iss_d   = '0;
                    rsp_d   = '0;
                    onset_d = '0;
                    mm_d    = '0;
                    first_d = '0;
                    sig_d   = '1;
                    perr_d  = 1'b0;
                    state_d = (sweep_len == '0) ? DONE : SEND_A;
                end
            end
            SEND_A: begin
                x_valid = 1'b1;
                x_out   = v_q;
                hs      = x_ready;
                if (x_ready) begin
                    iss_d   = 2'd1;
                    state_d = SEND_B;
                end
            end
            SEND_B: begin
                x_valid = 1'b1;
                x_out   = v_q ^ alpha_q;
                hs      = x_ready;
                if (x_ready) begin
                    iss_d   = 2'd2;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Pair results were folded into the counters when the second response landed.
                if (rsp_q == 2'd2) begin
                    iss_d   = '0;
                    rsp_d   = '0;
                    pairs_d = pairs_next;
                    if (pairs_next == len_q) begin
                        state_d = DONE;
`ifdef PLA_SWEEP_MISMATCH_STOP_EN
                    end else if (mm_q != '0) begin
                        state_d = DONE;
`endif
                    end else begin
                        v_d     = v_q + V_ONE;
                        state_d = SEND_A;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A response is legal once its request handshake happens, even in the same cycle.
        iss_eff = iss_q + {1'b0, hs};
        if (y_valid) begin
            if (iss_eff > rsp_q) begin
                sig_d = misr_next(sig_q, y_in);
                rsp_d = rsp_q + 2'd1;
                if (rsp_q == 2'd0) begin
                    ya_d = y_in;
                end else begin
                    if (ya_q) begin
                        onset_d = sat_inc(onset_q);
                    end
                    if (ya_q != y_in) begin
                        mm_d = sat_inc(mm_q);
                        if (mm_q == '0) begin
                            first_d = v_q;
                        end
                    end
                end
            end else begin
                perr_d = 1'b1;
            end
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign onset_count    = onset_q;
    assign mismatch_count = mm_q;
    assign first_mismatch = first_q;
    assign signature      = sig_q;
    assign protocol_err   = perr_q;

endmodule
